// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle for decode_stage
// master: fetch/execute environment; slave: the decode stage.
// flush, in_valid/in_ready/in_inst/in_pc, out_valid/out_ready/out_pc,
// decoded fields opcode/rs1/rs2/rd/func3/func7/func12, imm and decode flags.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [11:0]     func12;
  logic [XLEN-1:0] imm;
  logic            ecall;
  logic            ebreak;
  logic            mret;
  logic            branch;
  logic            invalid;
  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, rs1, rs2, rd, func3, func7, func12,
           imm, ecall, ebreak, mret, branch, invalid
  );
  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, rs1, rs2, rd, func3, func7, func12,
           imm, ecall, ebreak, mret, branch, invalid
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decoder with a 2-entry skid buffer
// clk, reset (synchronous, active-high); bus (slave) carries flush, the fetch beat
// in_valid/in_ready/in_inst/in_pc and the decoded execute beat out_valid/out_ready/
// out_pc, opcode/rs1/rs2/rd/func3/func7/func12, imm, ecall/ebreak/mret/branch/invalid.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:2]     inst;
    logic [XLEN-1:0] imm;
    logic            ecall;
    logic            ebreak;
    logic            mret;
    logic            branch;
    logic            invalid;
  } beat_t;
  // bit n set = major opcode n is legal; RV64 adds OP-IMM-32 (6) and OP-32 (14)
  localparam logic [31:0] LEGAL_OPS = (XLEN == 64) ? 32'h1B00_7179 : 32'h1B00_3139;
  logic [31:0] i;
  logic [4:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        r_type;
  logic        sys;
  logic        bad;
  beat_t       dec;
  beat_t       out_q, out_d, skid_q, skid_d;
  logic        out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic        acc, xfer, held;
  assign i  = bus.in_inst;
  assign op = i[6:2];
  assign f3 = i[14:12];
  assign f7 = i[31:25];
  always_comb begin
    r_type = op == 5'b01100 || (XLEN == 64 && op == 5'b01110);
    bad = i[1:0] != 2'b11 || !LEGAL_OPS[op]
      || (r_type && !(f7 == 7'h00 || f7 == 7'h20 || (ENABLE_M && f7 == 7'h01)))
      || (r_type && f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101))
      || (op == 5'b11000 && f3[2:1] == 2'b01)
      || (op == 5'b11001 && f3 != 3'b000);
    sys = !bad && op == 5'b11100 && f3 == 3'b000;
    dec.pc = bus.in_pc;
    dec.inst = i[31:2];
    dec.imm = (op inside {5'b00000, 5'b00100, 5'b11001, 5'b00110}) ? XLEN'($signed(i[31:20]))
      : op == 5'b01000 ? XLEN'($signed({i[31:25], i[11:7]}))
      : op == 5'b11000 ? XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}))
      : (op == 5'b01101 || op == 5'b00101) ? XLEN'($signed({i[31:12], 12'h000}))
      : op == 5'b11011 ? XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}))
      : op == 5'b11100 ? XLEN'(i[19:15])
      : '0;
    dec.ecall = sys && f7 == 7'h00 && i[24:20] == 5'd0;
    dec.ebreak = sys && f7 == 7'h00 && i[24:20] == 5'd1;
    dec.mret = sys && f7 == 7'h18 && i[24:20] == 5'd2;
    dec.branch = !bad && (op inside {5'b11011, 5'b11001, 5'b11000});
    dec.invalid = bad;
  end
  assign bus.in_ready = !skid_v_q && !reset;
  assign acc  = bus.in_valid && bus.in_ready;
  assign xfer = out_v_q && bus.out_ready;
  // out reg still occupied after this edge, so an accepted beat must go to the skid
  assign held = xfer ? skid_v_q : out_v_q;
  always_comb begin
    out_v_d  = !bus.flush && (acc || held);
    skid_v_d = !bus.flush && (acc ? held : skid_v_q && !xfer);
    out_d    = (acc && !held) ? dec : (xfer && skid_v_q) ? skid_q : out_q;
    skid_d   = (acc && held) ? dec : skid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
    end
  end
  assign bus.out_valid = out_v_q;
  assign bus.out_pc    = out_q.pc;
  assign bus.opcode    = out_q.inst[6:2];
  assign bus.rs1       = out_q.inst[19:15];
  assign bus.rs2       = out_q.inst[24:20];
  assign bus.rd        = out_q.inst[11:7];
  assign bus.func3     = out_q.inst[14:12];
  assign bus.func7     = out_q.inst[31:25];
  assign bus.func12    = out_q.inst[31:20];
  assign bus.imm       = out_q.imm;
  assign bus.ecall     = out_q.ecall;
  assign bus.ebreak    = out_q.ebreak;
  assign bus.mret      = out_q.mret;
  assign bus.branch    = out_q.branch;
  assign bus.invalid   = out_q.invalid;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed checks of two decode_stage builds against a queue model
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } beat_t;
  beat_t q[$];
  logic [4:0] op_tab[14];
  decode_stage_if #(.XLEN(32)) i32 ();
  decode_stage_if #(.XLEN(64)) i64 ();
  decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) u32 (.clk(clk), .reset(rst), .bus(i32));
  decode_stage #(.XLEN(64), .ENABLE_M(1'b0)) u64 (.clk(clk), .reset(rst), .bus(i64));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask
  function automatic logic [46:0] flds(input logic [31:0] i);
    return {i[6:2], i[19:15], i[24:20], i[11:7], i[14:12], i[31:25], i[31:20]};
  endfunction
  // returns {imm[63:0], ecall, ebreak, mret, branch, invalid}
  function automatic logic [68:0] ref_dec(input logic [31:0] i, input bit x64, input bit m);
    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] r2;
    longint imm;
    bit legal, rt, bad, sys, br;
    op = i[6:2];
    f3 = i[14:12];
    f7 = i[31:25];
    r2 = i[24:20];
    case (op)
      5'd0, 5'd4, 5'd25, 5'd6: imm = longint'($signed(i[31:20]));
      5'd8:                    imm = longint'($signed({i[31:25], i[11:7]}));
      5'd24:                   imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      5'd13, 5'd5:             imm = longint'($signed(i[31:12])) * 4096;
      5'd27:                   imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      5'd28:                   imm = longint'(i[19:15]);
      default:                 imm = 0;
    endcase
    if (!x64) imm = imm & 64'h0000_0000_FFFF_FFFF;
    legal = (op inside {5'd0, 5'd3, 5'd4, 5'd5, 5'd8, 5'd12, 5'd13, 5'd24, 5'd25, 5'd27, 5'd28})
      || (x64 && (op inside {5'd6, 5'd14}));
    rt = op == 5'd12 || (x64 && op == 5'd14);
    bad = i[1:0] != 2'b11 || !legal;
    if (rt && !(f7 == 7'h00 || f7 == 7'h20 || (m && f7 == 7'h01))) bad = 1;
    if (rt && f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5)) bad = 1;
    if (op == 5'd24 && (f3 == 3'd2 || f3 == 3'd3)) bad = 1;
    if (op == 5'd25 && f3 != 3'd0) bad = 1;
    sys = !bad && op == 5'd28 && f3 == 3'd0;
    br = !bad && (op inside {5'd24, 5'd25, 5'd27});
    return {imm, sys && f7 == 7'h00 && r2 == 5'd0, sys && f7 == 7'h00 && r2 == 5'd1,
            sys && f7 == 7'h18 && r2 == 5'd2, br, bad};
  endfunction
  function automatic logic [31:0] rnd_inst();
    logic [31:0] i;
    int unsigned r;
    i = $urandom;
    if ($urandom_range(0, 7) != 0) i[1:0] = 2'b11;
    if ($urandom_range(0, 5) != 0) i[6:2] = op_tab[$urandom_range(0, 13)];
    r = $urandom_range(0, 2);
    if ((i[6:2] == 5'd12 || i[6:2] == 5'd14) && $urandom_range(0, 3) != 0)
      i[31:25] = r == 0 ? 7'h00 : r == 1 ? 7'h20 : 7'h01;
    if (i[6:2] == 5'd28 && $urandom_range(0, 1) == 1) begin
      i[14:12] = 3'd0;
      i[31:25] = r == 2 ? 7'h18 : 7'h00;
      i[24:20] = 5'(r);
    end
    return i;
  endfunction
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [63:0] pc,
                       input bit ordy, input bit fl, input bit rs);
    beat_t h;
    logic [68:0] e32, e64;
    bit er;
    @(negedge clk);
    rst = rs;
    i32.flush = fl;
    i64.flush = fl;
    i32.in_valid = iv;
    i64.in_valid = iv;
    i32.in_inst = ins;
    i64.in_inst = ins;
    i32.in_pc = pc[31:0];
    i64.in_pc = pc;
    i32.out_ready = ordy;
    i64.out_ready = ordy;
    #1;
    er = !rs && q.size() < 2;
    chk("in_ready32", i32.in_ready, er);
    chk("in_ready64", i64.in_ready, er);
    chk("out_valid32", i32.out_valid, q.size() != 0);
    chk("out_valid64", i64.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      h = q[0];
      e32 = ref_dec(h.inst, 1'b0, 1'b1);
      e64 = ref_dec(h.inst, 1'b1, 1'b0);
      chk("pc32", i32.out_pc, h.pc[31:0]);
      chk("pc64", i64.out_pc, h.pc);
      chk("fields32", {i32.opcode, i32.rs1, i32.rs2, i32.rd, i32.func3, i32.func7, i32.func12}, flds(h.inst));
      chk("fields64", {i64.opcode, i64.rs1, i64.rs2, i64.rd, i64.func3, i64.func7, i64.func12}, flds(h.inst));
      chk("imm32", i32.imm, e32[68:5]);
      chk("imm64", i64.imm, e64[68:5]);
      chk("flags32", {i32.ecall, i32.ebreak, i32.mret, i32.branch, i32.invalid}, e32[4:0]);
      chk("flags64", {i64.ecall, i64.ebreak, i64.mret, i64.branch, i64.invalid}, e64[4:0]);
    end
    if (rs || fl) q.delete();
    else begin
      if (ordy && q.size() != 0) void'(q.pop_front());
      if (iv && er) q.push_back('{ins, pc});
    end
  endtask
  task automatic one(input logic [31:0] ins, input logic [63:0] pc);
    cycle(1'b1, ins, pc, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    op_tab = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd12, 5'd13, 5'd14, 5'd24, 5'd25, 5'd27, 5'd28, 5'd31};
    {i32.flush, i32.in_valid, i32.out_ready, i64.flush, i64.in_valid, i64.out_ready} = '0;
    i32.in_inst = '0;
    i64.in_inst = '0;
    i32.in_pc = '0;
    i64.in_pc = '0;
    cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0, 1'b1);
    chk("rst_ready", i32.in_ready, 1'b0);
    chk("rst_data32", {i32.out_pc, i32.imm, i32.opcode, i32.rd, i32.func12}, 64'h0);
    chk("rst_flags64", {i64.ecall, i64.ebreak, i64.mret, i64.branch, i64.invalid, i64.imm[31:0]}, 64'h0);
    one(32'hFFF00093, 64'h100);
    chk("addi_op", i32.opcode, 5'b00100);
    chk("addi_rd", i32.rd, 5'd1);
    chk("addi_imm32", i32.imm, 64'hFFFF_FFFF);
    chk("addi_imm64", i64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_pc", i32.out_pc, 64'h100);
    one(32'h02208033, 64'h104);
    chk("mul_m1", i32.invalid, 1'b0);
    chk("mul_m0", i64.invalid, 1'b1);
    one(32'h00000000, 64'h108);
    chk("zero_inv", i32.invalid, 1'b1);
    one(32'h00000073, 64'h10C);
    chk("ecall", {i32.ecall, i32.ebreak, i32.mret}, 3'b100);
    one(32'h00100073, 64'h110);
    chk("ebreak", {i32.ecall, i32.ebreak, i32.mret}, 3'b010);
    one(32'h30200073, 64'h114);
    chk("mret", {i64.ecall, i64.ebreak, i64.mret}, 3'b001);
    one(32'h0000006F, 64'h118);
    chk("jal_br", i32.branch, 1'b1);
    chk("jal_imm", i64.imm, 64'h0);
    one(32'h800000B7, 64'h11C);
    chk("lui64", i64.imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui32", i32.imm, 64'h8000_0000);
    one(32'h0010809B, 64'h120);
    chk("addiw64", i64.invalid, 1'b0);
    chk("addiw32", i32.invalid, 1'b1);
    cycle(1'b1, 32'h00100093, 64'h200, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 64'h204, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 64'h208, 1'b0, 1'b0, 1'b0);
    chk("bp_ready", i32.in_ready, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h00300193, 64'h208, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_drained", i32.out_valid, 1'b0);
    cycle(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 64'h304, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00300193, 64'h308, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_ov", i32.out_valid, 1'b0);
    chk("flush_rdy", i64.in_ready, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h00100093, 64'h400, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 64'h404, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("rst_stall_ov", i64.out_valid, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      bit fl, rs;
      fl = $urandom_range(0, 39) == 0;
      rs = $urandom_range(0, 199) == 0;
      cycle($urandom_range(0, 3) != 0, rnd_inst(), {$urandom, $urandom},
            !fl && $urandom_range(0, 2) != 0, fl, rs);
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
